// File: rtl/dcache_pkg.sv
// dcache_pkg: cache geometry, address field positions and FSM encoding.
package dcache_pkg;
  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 4;
  localparam int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int SETS          = 1 << SET_ADDR_LEN;
  localparam int OFF_LSB       = 2;
  localparam int SET_LSB       = OFF_LSB + LINE_ADDR_LEN;
  localparam int TAG_LSB       = SET_LSB + SET_ADDR_LEN;

  typedef logic [LINE_ADDR_LEN-1:0] off_t;
  typedef logic [SET_ADDR_LEN-1:0]  set_t;
  typedef logic [TAG_ADDR_LEN-1:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  function automatic logic [31:0] word_addr(
    input tag_t t,
    input set_t s,
    input off_t o
  );
    return {t, s, o, 2'b00};
  endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: MEM-stage request/response and word-serial memory bus.
interface dcache_ctrl_if;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        DCacheMiss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output rd_req, wr_req, addr, wr_data, wr_be,
    output mem_rdata, mem_ack,
    input  rd_data, DCacheMiss,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_data, wr_be,
    input  mem_rdata, mem_ack,
    output rd_data, DCacheMiss,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_mem_if.sv
// dcache_mem_if: word counter and registered memory handshake for bursts.
module dcache_mem_if
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_we,
  input  tag_t        start_tag,
  input  set_t        start_set,
  input  logic [31:0] word_in,
  input  logic        ack,
  output off_t        cnt,
  output off_t        nxt_idx,
  output logic        last_ack,
  output logic        req,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] wdata
);
  logic step;

  assign step     = req && ack;
  assign last_ack = step && (cnt == off_t'(LINE_WORDS - 1));
  assign nxt_idx  = start ? '0 : cnt + 1'b1;

  // a new burst may start on the last ack of the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      req   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (start) begin
      cnt   <= '0;
      req   <= 1'b1;
      we    <= start_we;
      addr  <= word_addr(start_tag, start_set, '0);
      wdata <= start_we ? word_in : '0;
    end else if (last_ack) begin
      cnt <= '0;
      req <= 1'b0;
      we  <= 1'b0;
    end else if (step) begin
      cnt                     <= nxt_idx;
      addr[SET_LSB-1:OFF_LSB] <= nxt_idx;
      wdata                   <= we ? word_in : '0;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache.
// Define DCACHE_STATS_EN to add hit_cnt/miss_cnt counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic         CPU_CLK,
  input  logic         CPU_RST,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;
  tag_t            tags  [SETS];
  logic [31:0]     lines [SETS][LINE_WORDS];

  state_t state;
  tag_t   miss_tag;
  set_t   miss_set;

  logic  req, hit, miss_start, victim_dirty;
  tag_t  req_tag;
  set_t  req_set, cur_set;
  off_t  req_off, cnt, nxt_idx;
  logic  last_ack, wb_done, fill_done, fill_we;
  logic  burst_start, burst_we;
  tag_t  burst_tag;
  logic [31:0] word_in;
  wire   unused_addr_lsb = &{1'b0, bus.addr[1:0]};

  assign req     = bus.rd_req || bus.wr_req;
  assign req_off = bus.addr[SET_LSB-1:OFF_LSB];
  assign req_set = bus.addr[TAG_LSB-1:SET_LSB];
  assign req_tag = bus.addr[31:TAG_LSB];

  assign hit = (state == IDLE) && req &&
               valid[req_set] && (tags[req_set] == req_tag);
  assign miss_start   = (state == IDLE) && req && !hit;
  assign victim_dirty = valid[req_set] && dirty[req_set];

  assign bus.DCacheMiss = req && !hit && !CPU_RST;
  assign bus.rd_data    = hit ? lines[req_set][req_off] : '0;

  assign cur_set     = (state == IDLE) ? req_set : miss_set;
  assign wb_done     = (state == WB) && last_ack;
  assign fill_done   = (state == FILL) && last_ack;
  assign fill_we     = (state == FILL) && bus.mem_req && bus.mem_ack;
  assign burst_start = miss_start || wb_done;
  assign burst_we    = miss_start && victim_dirty;
  assign burst_tag   = !miss_start  ? miss_tag :
                       victim_dirty ? tags[req_set] : req_tag;
  assign word_in     = lines[cur_set][nxt_idx];

  dcache_mem_if u_mem (
    .clk      (CPU_CLK),
    .rst      (CPU_RST),
    .start    (burst_start),
    .start_we (burst_we),
    .start_tag(burst_tag),
    .start_set(cur_set),
    .word_in  (word_in),
    .ack      (bus.mem_ack),
    .cnt      (cnt),
    .nxt_idx  (nxt_idx),
    .last_ack (last_ack),
    .req      (bus.mem_req),
    .we       (bus.mem_we),
    .addr     (bus.mem_addr),
    .wdata    (bus.mem_wdata)
  );

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_tag <= '0;
      miss_set <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            if (bus.wr_req) dirty[req_set] <= 1'b1;
          end else if (miss_start) begin
            miss_tag       <= req_tag;
            miss_set       <= req_set;
            valid[req_set] <= 1'b0;
            state          <= victim_dirty ? WB : FILL;
          end
        end
        WB: if (last_ack) state <= FILL;
        FILL: begin
          if (last_ack) begin
            valid[miss_set] <= 1'b1;
            dirty[miss_set] <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // line data and tags carry no reset; validity alone guards them
  always_ff @(posedge CPU_CLK) begin
    if (hit && bus.wr_req) begin
      for (int b = 0; b < 4; b++)
        if (bus.wr_be[b])
          lines[req_set][req_off][8*b +: 8] <= bus.wr_data[8*b +: 8];
    end
    if (fill_we) lines[miss_set][cnt] <= bus.mem_rdata;
    if (fill_done) tags[miss_set] <= miss_tag;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
